// File: rtl/cgra0_out_pkg.sv
// Shared constants, state encoding and lane helpers for the CGRA output stream packer.
package cgra0_out_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int LANES          = 4;
   localparam int LANE_W         = $clog2(LANES);
   localparam int OUT_WIDTH      = DATA_WIDTH * LANES;
   localparam int FIFO_DEPTH_LOG = 4;
   localparam int AF_MARGIN      = 2;
   localparam int AF_LEVEL       = (1 << FIFO_DEPTH_LOG) - AF_MARGIN;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } pk_state_t;

   typedef logic [LANES-1:0][DATA_WIDTH-1:0] lane_arr_t;

   // Keep lanes below 'used' and zero the rest (tail beat of a run).
   function automatic lane_arr_t pad_lanes(input lane_arr_t lanes, input logic [LANE_W-1:0] used);
      lane_arr_t res;
      res = lanes;
      for (int i = 0; i < LANES; i++) begin
         if (i >= int'(used)) res[i] = '0;
      end
      return res;
   endfunction

endpackage

// File: rtl/cgra0_sync_fifo.sv
// Synchronous beat FIFO with registered read data, occupancy count and a flush input.
module cgra0_sync_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH_LOG  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic [DEPTH_LOG:0]    count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int CNT_W = DEPTH_LOG + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH_LOG-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  push_ok, pop_ok;

   assign full       = (count_q == CNT_W'(DEPTH));
   assign empty      = (count_q == '0);
   assign count      = count_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

   // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
   always_comb begin
      pop_ok       = pop && !empty && !clr;
      push_ok      = push && (!full || pop_ok) && !clr;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = pop_ok;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
      if (pop_ok) dout_d = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

endmodule

// File: rtl/cgra0_out_stream_packer.sv
// Packs 16-bit PE output words four at a time into 64-bit beats and queues them for the host.
//   state | meaning
//   IDLE  | after reset, waiting for start; in_we ignored
//   RUN   | accepting words into lanes, staging full beats for push
//   FLUSH | one cycle: push the staged or zero-padded final beat
//   DONE  | run complete, last beat pushed; in_we ignored until start
module cgra0_out_stream_packer
   import cgra0_out_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           qtd,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_we,
   output logic                  almost_full,
   input  logic                  out_rd_en,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   output logic                  out_available,
   output logic                  done,
   output logic                  overflow
);

   localparam int CNT_W = FIFO_DEPTH_LOG + 1;

   pk_state_t             state_q, state_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic [31:0]           word_cnt_q, word_cnt_d;
   logic [31:0]           qtd_q, qtd_d;
   lane_arr_t             lanes_q, lanes_d;
   logic [OUT_WIDTH-1:0]  stage_q, stage_d;
   logic                  stage_vld_q, stage_vld_d;
   logic                  overflow_q, overflow_d;
   logic                  almost_full_q, almost_full_d;

   logic                  fifo_push, fifo_full, fifo_empty;
   logic [OUT_WIDTH-1:0]  fifo_din;
   logic [CNT_W-1:0]      fifo_count, occ_nxt;
   logic                  push_ok, pop_ok;

   assign pop_ok        = out_rd_en && !fifo_empty && !start;
   assign done          = (state_q == DONE);
   assign overflow      = overflow_q;
   assign almost_full   = almost_full_q;
   assign out_available = !fifo_empty;

   always_comb begin
      state_d       = state_q;
      lane_d        = lane_q;
      word_cnt_d    = word_cnt_q;
      qtd_d         = qtd_q;
      lanes_d       = lanes_q;
      stage_d       = stage_q;
      stage_vld_d   = 1'b0;
      overflow_d    = overflow_q;
      fifo_push     = stage_vld_q;
      fifo_din      = stage_q;
      push_ok       = 1'b0;
      occ_nxt       = '0;
      almost_full_d = 1'b0;

      unique case (state_q)
         IDLE: ;
         RUN: begin
            if (in_we) begin
               lanes_d[lane_q] = in_data;
               lane_d          = lane_q + LANE_W'(1);
               word_cnt_d      = word_cnt_q + 32'd1;
               if (lane_q == LANE_W'(LANES - 1)) begin
                  stage_d     = lanes_d;
                  stage_vld_d = 1'b1;
               end
               if (word_cnt_d == qtd_q) state_d = FLUSH;
            end
         end
         // Entered with lane 0 the final beat sits in staging; otherwise pad it here.
         FLUSH: begin
            if (lane_q != '0) begin
               fifo_push = 1'b1;
               fifo_din  = pad_lanes(lanes_q, lane_q);
            end
            lane_d  = '0;
            state_d = DONE;
         end
         DONE: ;
      endcase

      if (start) begin
         state_d     = (qtd == 32'd0) ? DONE : RUN;
         lane_d      = '0;
         word_cnt_d  = '0;
         qtd_d       = qtd;
         lanes_d     = '0;
         stage_vld_d = 1'b0;
         overflow_d  = 1'b0;
         fifo_push   = 1'b0;
      end

      push_ok = fifo_push && (!fifo_full || pop_ok);
      if (fifo_push && !push_ok) overflow_d = 1'b1;
      occ_nxt       = start ? '0 : (fifo_count + CNT_W'(push_ok) - CNT_W'(pop_ok));
      almost_full_d = (occ_nxt >= CNT_W'(AF_LEVEL));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         lane_q        <= '0;
         word_cnt_q    <= '0;
         qtd_q         <= '0;
         lanes_q       <= '0;
         stage_q       <= '0;
         stage_vld_q   <= 1'b0;
         overflow_q    <= 1'b0;
         almost_full_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lane_q        <= lane_d;
         word_cnt_q    <= word_cnt_d;
         qtd_q         <= qtd_d;
         lanes_q       <= lanes_d;
         stage_q       <= stage_d;
         stage_vld_q   <= stage_vld_d;
         overflow_q    <= overflow_d;
         almost_full_q <= almost_full_d;
      end
   end

   cgra0_sync_fifo #(
      .DATA_WIDTH (OUT_WIDTH),
      .DEPTH_LOG  (FIFO_DEPTH_LOG)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clr        (start),
      .push       (fifo_push),
      .din        (fifo_din),
      .pop        (out_rd_en),
      .dout       (out_data),
      .dout_valid (out_valid),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

endmodule

// File: tb/tb_cgra0_out_stream_packer.sv
// Scoreboard bench for the output stream packer: directed scenarios plus randomized runs.
module tb_cgra0_out_stream_packer;

   logic        clk = 1'b0;
   logic        rst, start, in_we, out_rd_en;
   logic [31:0] qtd;
   logic [15:0] in_data;
   logic        almost_full, out_valid, out_available, done, overflow;
   logic [63:0] out_data;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [15:0] words_q[$];
   logic [63:0] exp_beat;
   int          pops;

   always #5 clk = ~clk;

   cgra0_out_stream_packer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .qtd           (qtd),
      .in_data       (in_data),
      .in_we         (in_we),
      .almost_full   (almost_full),
      .out_rd_en     (out_rd_en),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_available (out_available),
      .done          (done),
      .overflow      (overflow)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented beat must match the oldest expected beat.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected actual=%h required=none", out_data);
         end else begin
            exp_beat = exp_q.pop_front();
            if (out_data !== exp_beat) begin
               failures++;
               $display("FAIL beat_data actual=%h required=%h", out_data, exp_beat);
            end
         end
      end
   end

   // Reference: group words by four, lane 0 earliest, zero-pad the tail; keep at most cap beats.
   task automatic model_run(input int cap);
      logic [63:0] beat;
      int          n;
      beat = '0;
      n    = words_q.size();
      for (int i = 0; i < n; i++) begin
         beat[16*(i%4) +: 16] = words_q[i];
         if ((i % 4) == 3 || i == n - 1) begin
            if (exp_q.size() < cap) exp_q.push_back(beat);
            beat = '0;
         end
      end
   endtask

   task automatic do_start(input logic [31:0] q);
      cycle();
      exp_q.delete();
      start = 1'b1;
      qtd   = q;
      cycle();
      start = 1'b0;
   endtask

   task automatic send(input int from, input int to, input bit rnd);
      for (int i = from; i < to; i++) begin
         if (rnd) begin
            while ($urandom_range(3) == 0) begin
               in_we     = 1'b0;
               in_data   = 16'($urandom);
               out_rd_en = 1'($urandom_range(1));
               cycle();
            end
            out_rd_en = 1'($urandom_range(1));
         end
         in_we   = 1'b1;
         in_data = words_q[i];
         cycle();
      end
      in_we     = 1'b0;
      out_rd_en = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         cycle();
         n++;
      end
      chk(name, 64'(done), 64'd1);
   endtask

   task automatic drain(output int np);
      np = 0;
      for (int i = 0; i < 40 && out_available === 1'b1; i++) begin
         out_rd_en = 1'b1;
         cycle();
         out_rd_en = 1'b0;
         chk("out_valid_after_rd", 64'(out_valid), 64'd1);
         np++;
      end
      cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst = 1'b1; start = 1'b0; qtd = '0; in_data = '0; in_we = 1'b0; out_rd_en = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      chk("rst_done",        64'(done),          64'd0);
      chk("rst_available",   64'(out_available), 64'd0);
      chk("rst_almost_full", 64'(almost_full),   64'd0);
      chk("rst_overflow",    64'(overflow),      64'd0);
      chk("rst_out_valid",   64'(out_valid),     64'd0);
      chk("rst_out_data",    out_data,           64'd0);

      // Two full beats.
      words_q.delete();
      for (int i = 1; i <= 8; i++) words_q.push_back(16'(i));
      do_start(32'd8);
      exp_q.push_back(64'h0004_0003_0002_0001);
      exp_q.push_back(64'h0008_0007_0006_0005);
      send(0, 8, 1'b0);
      wait_done("t1_done");
      chk("t1_available", 64'(out_available), 64'd1);
      drain(pops);
      chk("t1_beats", 64'(pops), 64'd2);
      chk("t1_drained", 64'(exp_q.size()), 64'd0);

      // Partial tail beat is zero padded.
      words_q.delete();
      for (int i = 0; i < 5; i++) words_q.push_back(16'(16'hA0 + i));
      do_start(32'd5);
      exp_q.push_back(64'h00A3_00A2_00A1_00A0);
      exp_q.push_back(64'h0000_0000_0000_00A4);
      send(0, 5, 1'b0);
      wait_done("t2_done");
      drain(pops);
      chk("t2_beats", 64'(pops), 64'd2);
      chk("t2_drained", 64'(exp_q.size()), 64'd0);

      // Empty run: done immediately, words ignored.
      do_start(32'd0);
      chk("t3_done_now", 64'(done), 64'd1);
      words_q.delete();
      for (int i = 0; i < 4; i++) words_q.push_back(16'($urandom));
      send(0, 4, 1'b0);
      cycle();
      chk("t3_available", 64'(out_available), 64'd0);
      chk("t3_done_held", 64'(done), 64'd1);
      out_rd_en = 1'b1;
      cycle();
      out_rd_en = 1'b0;
      chk("t3_pop_empty", 64'(out_valid), 64'd0);

      // Overflow with no pops: first 16 beats kept, rest dropped.
      words_q.delete();
      for (int i = 1; i <= 80; i++) words_q.push_back(16'(i));
      do_start(32'd80);
      model_run(16);
      send(0, 52, 1'b0);
      cycle();
      chk("t4_af_at_13", 64'(almost_full), 64'd0);
      send(52, 56, 1'b0);
      cycle();
      chk("t4_af_at_14", 64'(almost_full), 64'd1);
      send(56, 64, 1'b0);
      cycle();
      chk("t4_no_ovf_at_16", 64'(overflow), 64'd0);
      send(64, 80, 1'b0);
      wait_done("t4_done");
      chk("t4_overflow", 64'(overflow), 64'd1);
      chk("t4_af_full", 64'(almost_full), 64'd1);
      drain(pops);
      chk("t4_beats", 64'(pops), 64'd16);
      chk("t4_drained", 64'(exp_q.size()), 64'd0);
      chk("t4_af_empty", 64'(almost_full), 64'd0);
      chk("t4_ovf_sticky", 64'(overflow), 64'd1);

      // Push into a full FIFO while popping in the same cycle.
      words_q.delete();
      for (int i = 0; i < 68; i++) words_q.push_back(16'(16'h100 + i));
      do_start(32'd68);
      model_run(17);
      send(0, 64, 1'b0);
      cycle();
      chk("t5_af_full", 64'(almost_full), 64'd1);
      send(64, 67, 1'b0);
      in_we   = 1'b1;
      in_data = words_q[67];
      cycle();
      in_we     = 1'b0;
      out_rd_en = 1'b1;
      cycle();
      out_rd_en = 1'b0;
      chk("t5_pop_valid", 64'(out_valid), 64'd1);
      chk("t5_no_overflow", 64'(overflow), 64'd0);
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_af_still", 64'(almost_full), 64'd1);
      drain(pops);
      chk("t5_beats", 64'(pops), 64'd16);
      chk("t5_drained", 64'(exp_q.size()), 64'd0);

      // Restart in the middle of a run.
      words_q.delete();
      for (int i = 0; i < 12; i++) words_q.push_back(16'($urandom));
      do_start(32'd12);
      send(0, 6, 1'b0);
      cycle();
      chk("t6_avail_before", 64'(out_available), 64'd1);
      do_start(32'd4);
      chk("t6_flushed", 64'(out_available), 64'd0);
      chk("t6_done_clear", 64'(done), 64'd0);
      words_q.delete();
      for (int i = 0; i < 4; i++) words_q.push_back(16'($urandom));
      model_run(16);
      send(0, 4, 1'b0);
      wait_done("t6_done");
      drain(pops);
      chk("t6_beats", 64'(pops), 64'd1);
      chk("t6_drained", 64'(exp_q.size()), 64'd0);

      // Randomized runs with gaps and concurrent pops.
      for (int r = 0; r < 10; r++) begin
         int n;
         n = int'($urandom_range(60, 1));
         words_q.delete();
         for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
         do_start(32'(n));
         model_run(16);
         send(0, n, 1'b1);
         wait_done("rnd_done");
         chk("rnd_no_overflow", 64'(overflow), 64'd0);
         drain(pops);
         chk("rnd_drained", 64'(exp_q.size()), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
